imem_loader: RTL and testbench

- Writer side of the instruction-memory interface. Receives a byte stream from a host link (a UART receiver, for example) and assembles little-endian 32-bit instruction words.
- Issues single-cycle write strobes into the instruction memory, word-addressed from byte address 0.
- Holds the processor in reset while a load is in progress.
- Reports completion and error status.

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The master side is the loader. The slave side is the host link and memory model.
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  // rx_valid qualifies rx_data for exactly one byte per asserted cycle.
  // There is no ready: the loader must take every byte it is offered.
  // we is a single-cycle strobe. waddr/wdata are meaningful only while we=1.
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (
    input  rx_data, rx_valid,
    output we, waddr, wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed little-endian byte frames become word writes.
// The optional trailing XOR checksum byte is enabled by the macro IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int MAX_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.master     bus,
  output logic              busy,
  output logic              cpu_rst_hold,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
`ifdef IMEM_LOADER_CSUM_EN
    ,CSUM  = 3'd6
`endif
  } state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t            state, state_n;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [15:0]       word_cnt;
  logic [1:0]        lane_idx;
  logic [7:0]        b0, b1, b2;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [31:0]       wdata_r;
  logic [15:0]       n_len;
  logic              last_we;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum;
`endif

  assign n_len   = {bus.rx_data, len_lo};
  // word_cnt already counts the word being strobed, so this marks the final write cycle.
  assign last_we = we_r && (word_cnt == len);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_n = LEN_LO;
      LEN_LO:          if (bus.rx_valid) state_n = LEN_HI;
      LEN_HI: begin
        if (bus.rx_valid) begin
          if (n_len == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_n = CSUM;
`else
            state_n = DONE;
`endif
          end else if ({1'b0, n_len} > MAX_N) begin
            state_n = ERR;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (last_we) begin
`ifdef IMEM_LOADER_CSUM_EN
          // A checksum byte may arrive back-to-back in the final write cycle.
          if (bus.rx_valid) state_n = (bus.rx_data == csum) ? DONE : ERR;
          else              state_n = CSUM;
`else
          state_n = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: if (bus.rx_valid) state_n = (bus.rx_data == csum) ? DONE : ERR;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo   <= '0;
      len      <= '0;
      word_cnt <= '0;
      lane_idx <= '0;
      b0       <= '0;
      b1       <= '0;
      b2       <= '0;
      we_r     <= 1'b0;
      waddr_r  <= '0;
      wdata_r  <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum     <= '0;
`endif
    end else begin
      we_r <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            word_cnt <= '0;
            lane_idx <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum     <= '0;
`endif
          end
        end
        LEN_LO: if (bus.rx_valid) len_lo <= bus.rx_data;
        LEN_HI: if (bus.rx_valid) len <= n_len;
        DATA: begin
          if (bus.rx_valid && !last_we) begin
            case (lane_idx)
              2'd0: b0 <= bus.rx_data;
              2'd1: b1 <= bus.rx_data;
              2'd2: b2 <= bus.rx_data;
              default: begin
                we_r     <= 1'b1;
                waddr_r  <= ADDR_W'({word_cnt, 2'b00});
                wdata_r  <= {bus.rx_data, b2, b1, b0};
                word_cnt <= word_cnt + 16'd1;
              end
            endcase
            lane_idx <= lane_idx + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
            csum     <= csum ^ bus.rx_data;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.we       = we_r;
  assign bus.waddr    = waddr_r;
  assign bus.wdata    = wdata_r;
  assign busy         = (state == LEN_LO) || (state == LEN_HI) || (state == DATA)
`ifdef IMEM_LOADER_CSUM_EN
                        || (state == CSUM)
`endif
                        ;
  assign cpu_rst_hold = busy;
  assign done         = (state == DONE);
  assign err          = (state == ERR);
  assign state_dbg    = state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a scoreboard queue of expected writes is drained by a monitor.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, cpu_rst_hold, done, err;
  logic [2:0] state_dbg;

  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader #(.MAX_WORDS(256), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .cpu_rst_hold (cpu_rst_hold),
    .done         (done),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  logic [7:0]  fq[$];
  int          checks = 0;
  int          fails  = 0;
  int          we_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is popped against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_we", {bus.waddr, bus.wdata}, 64'hx);
      end else begin
        chk("write", {bus.waddr, bus.wdata}, exp_q.pop_front());
      end
    end
  end

  // Driver tasks are entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int gap);
    foreach (fq[i]) send_byte(fq[i], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic add_csum(input logic [7:0] c);
`ifdef IMEM_LOADER_CSUM_EN
    fq.push_back(c);
`else
    if (c === 8'hxx) fq.push_back(c);
`endif
  endtask

  task automatic wait_status(input string name);
    int n = 0;
    while (!(done || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic end_check(input string name, input logic exp_done, input int exp_we);
    wait_status(name);
    chk({name, "_done"}, 64'(done), 64'(exp_done));
    chk({name, "_err"},  64'(err),  64'(!exp_done));
    chk({name, "_hold"}, 64'(cpu_rst_hold), 64'd0);
    chk({name, "_nwe"},  64'(we_cnt), 64'(exp_we));
    chk({name, "_qempty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic two_word_frame();
    fq = {8'h02, 8'h00, 8'h83, 8'h20, 8'h40, 8'h00, 8'h03, 8'h21, 8'h80, 8'h00};
    exp_q.push_back({32'h0, 32'h00402083});
    exp_q.push_back({32'h4, 32'h00802103});
    we_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {29'd0, bus.we, busy, cpu_rst_hold, done, err, state_dbg},
        {29'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
    chk("reset_bus", {bus.waddr, bus.wdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back two-word load.
    two_word_frame();
    pulse_start();
    chk("start_busy", 64'(busy), 64'd1);
`ifdef IMEM_LOADER_CSUM_EN
    add_csum(8'h41);
    send_frame(0);
`else
    send_frame(0);
    chk("last_we_cycle", {62'd0, bus.we, done}, {62'd0, 1'b1, 1'b0});
    @(negedge clk);
    chk("done_after_we", {62'd0, done, cpu_rst_hold}, {62'd0, 1'b1, 1'b0});
`endif
    end_check("b2b", 1'b1, 2);

    // Same stream with three idle cycles between bytes.
    two_word_frame();
    add_csum(8'h41);
    pulse_start();
    chk("done_cleared", 64'(done), 64'd0);
    send_frame(3);
    end_check("gaps", 1'b1, 2);

    // Length 257 exceeds MAX_WORDS.
    we_cnt = 0;
    fq = {8'h01, 8'h01};
    pulse_start();
    send_frame(0);
    end_check("len_err", 1'b0, 0);
    chk("len_err_busy", 64'(busy), 64'd0);

    we_cnt = 0;
    fq = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    add_csum(8'h13);
    exp_q.push_back({32'h0, 32'h00000013});
    pulse_start();
    chk("err_cleared", 64'(err), 64'd0);
    send_frame(0);
    end_check("after_err", 1'b1, 1);

    // Reset in the middle of the first word.
    we_cnt = 0;
    fq = {8'h02, 8'h00, 8'h83, 8'h20};
    pulse_start();
    send_frame(0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outputs", {29'd0, bus.we, busy, cpu_rst_hold, done, err, state_dbg}, 64'd0);
    chk("midrst_bus", {bus.waddr, bus.wdata}, 64'd0);
    chk("midrst_nwe", 64'(we_cnt), 64'd0);
    fq = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    add_csum(8'h00);
    exp_q.push_back({32'h0, 32'hDDCCBBAA});
    pulse_start();
    send_frame(0);
    end_check("after_rst", 1'b1, 1);

    // A start pulse in DATA must not disturb the load.
    two_word_frame();
    pulse_start();
    foreach (fq[i]) begin
      if (i == 4) pulse_start();
      send_byte(fq[i], 0);
    end
    fq = {};
    add_csum(8'h41);
    send_frame(0);
    end_check("start_in_data", 1'b1, 2);

    // Zero-length frame.
    we_cnt = 0;
    fq = {8'h00, 8'h00};
    add_csum(8'h00);
    pulse_start();
    send_frame(0);
    end_check("zero_len", 1'b1, 0);

`ifdef IMEM_LOADER_CSUM_EN
    // Wrong checksum: both writes still land, then ERR.
    two_word_frame();
    add_csum(8'h42);
    pulse_start();
    send_frame(0);
    end_check("bad_csum", 1'b0, 2);
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
